// File: rtl/uart_pkg.sv
// Shared UART types and constants: Gray-coded transmitter states, parity
// selectors and the prescale clamp applied when a frame is accepted.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } tx_state_t;

    localparam logic       PAR_EVEN     = 1'b0;
    localparam logic       PAR_ODD      = 1'b1;
    localparam logic [5:0] PRESCALE_MIN = 6'd2;

    // A bit period below two clocks would leave the edge counter no room to wrap.
    function automatic logic [5:0] eff_prescale(input logic [5:0] p);
        return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
    endfunction

endpackage

// File: rtl/uart_tx_tick_cnt.sv
// Bit timing for the transmitter: an edge counter that wraps every prescale_i
// clocks and a data-bit index that advances on each wrap.
module uart_tx_tick_cnt #(
    parameter int DATA_WIDTH = 8,
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [5:0]       prescale_i,
    output logic             bit_done_o,
    output logic [IDX_W-1:0] bit_idx_o
);

    logic [5:0]       edge_cnt_q;
    logic [IDX_W-1:0] bit_idx_q;

    assign bit_done_o = (edge_cnt_q == prescale_i - 6'd1);
    assign bit_idx_o  = bit_idx_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt_q <= '0;
            bit_idx_q  <= '0;
        end else if (clr_i) begin
            edge_cnt_q <= '0;
            bit_idx_q  <= '0;
        end else if (en_i) begin
            if (bit_done_o) begin
                edge_cnt_q <= '0;
                bit_idx_q  <= bit_idx_q + IDX_W'(1);
            end else begin
                edge_cnt_q <= edge_cnt_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit. TX_OUT and Busy are driven straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;
    logic [5:0]            prescale_q, prescale_d;

    logic                  bit_done;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  cnt_en;
    logic                  cnt_clr;

    // The index is cleared as START ends so the first data bit is index 0.
    assign cnt_en   = (state_q != IDLE);
    assign cnt_clr  = (state_q == IDLE) || ((state_q == START) && bit_done);
    assign next_idx = bit_idx + IDX_W'(1);

    uart_tx_tick_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_tick_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (cnt_en),
        .clr_i      (cnt_clr),
        .prescale_i (prescale_q),
        .bit_done_o (bit_done),
        .bit_idx_o  (bit_idx)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            prescale_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            prescale_q <= prescale_d;
        end
    end

    // NOTE: every signal is given a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        parity_d   = parity_q;
        prescale_d = prescale_q;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (DATA_VALID) begin
                    data_d     = P_DATA;
                    par_en_d   = PAR_EN;
                    parity_d   = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
                    prescale_d = eff_prescale(Prescale);
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d    = data_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_IDX) begin
                        if (par_en_q) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d = data_q[next_idx];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks every bit period of each frame against
// hand-derived line values, frame length via Busy, and async reset abort.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int errors = 0;
    int checks = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drives one request at a negedge, lets the next posedge accept it, then
    // samples every cycle of the frame on falling edges. On return the bench
    // sits at the falling edge just after Busy fell.
    task automatic send_frame(input string tag, input logic [7:0] data,
                              input logic pen, input logic ptyp,
                              input logic [5:0] presc, input int period,
                              input logic par_exp, input logic hold,
                              input logic do_mid, input logic [7:0] mid_data);
        logic exp_bits[12];
        logic obs_bit;
        logic busy_ok;
        int   nbits;
        nbits = pen ? 11 : 10;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = data[i];
        exp_bits[9]       = par_exp;
        exp_bits[nbits-1] = 1'b1;

        P_DATA     = data;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Prescale   = presc;
        DATA_VALID = 1'b1;
        chk({tag, ".idle_tx"}, TX_OUT, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) DATA_VALID = 1'b0;
        chk({tag, ".tx_fall"}, TX_OUT, 1'b0);

        busy_ok = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            obs_bit = exp_bits[k];
            for (int c = 0; c < period; c++) begin
                if (TX_OUT !== exp_bits[k]) obs_bit = TX_OUT;
                if (Busy !== 1'b1) busy_ok = 1'b0;
                if (do_mid && k == 3 && c == 0) begin
                    P_DATA   = mid_data;
                    PAR_TYP  = ~ptyp;
                end
                @(negedge CLK);
            end
            chk($sformatf("%s.bit%0d", tag, k), obs_bit, exp_bits[k]);
        end
        chk({tag, ".busy_held"}, busy_ok, 1'b1);
        chk({tag, ".busy_fall"}, Busy, 1'b0);
        chk({tag, ".tx_idle_after"}, TX_OUT, 1'b1);
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        repeat (3) @(negedge CLK);
        chk("reset.tx", TX_OUT, 1'b1);
        chk("reset.busy", Busy, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("post_reset.tx", TX_OUT, 1'b1);

        // 0xA5, 8 clocks per bit, no parity: 0,1,0,1,0,0,1,0,1,1 over 80 cycles
        send_frame("a5_p8", 8'hA5, 1'b0, 1'b0, 6'd8, 8, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (3) @(negedge CLK);

        // 0x01 at 16 clocks per bit: even parity bit 1, odd parity bit 0
        send_frame("01_even", 8'h01, 1'b1, 1'b0, 6'd16, 16, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge CLK);
        send_frame("01_odd", 8'h01, 1'b1, 1'b1, 6'd16, 16, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge CLK);

        // 0xFF odd parity at 32 clocks per bit: parity 1, 352-cycle frame
        send_frame("ff_odd", 8'hFF, 1'b1, 1'b1, 6'd32, 32, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge CLK);

        // DATA_VALID held across frames; P_DATA switched to 0xC3 mid-frame
        send_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 6'd8, 8, 1'b0, 1'b1, 1'b1, 8'hC3);
        send_frame("b2b_c3", 8'hC3, 1'b0, 1'b0, 6'd8, 8, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge CLK);

        // Reset pulsed during data bit 3 of 0x00
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (34) @(negedge CLK);
        chk("rst_mid.pre_tx", TX_OUT, 1'b0);
        chk("rst_mid.pre_busy", Busy, 1'b1);
        RST = 1'b1;
        #1;
        chk("rst_mid.async_tx", TX_OUT, 1'b1);
        chk("rst_mid.async_busy", Busy, 1'b0);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid.idle_tx", TX_OUT, 1'b1);
        chk("rst_mid.idle_busy", Busy, 1'b0);
        send_frame("after_rst_55", 8'h55, 1'b0, 1'b0, 6'd8, 8, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge CLK);

        // Prescale 1 is clamped to 2 clocks per bit: 20-cycle frame
        send_frame("80_p1", 8'h80, 1'b0, 1'b0, 6'd1, 2, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
